// File: rtl/seg7_scan_decoder.sv
// Watches a multiplexed 7-segment bus and recovers the hex digit shown on each position.
// A pair {an,seg} must hold for STABLE_CYCLES edges before it is decoded once into its slot.
module seg7_scan_decoder #(
    parameter  int DIGITS        = 4,
    parameter  int STABLE_CYCLES = 4,
    localparam int EW            = (DIGITS > 1) ? $clog2(DIGITS) : 1,
    localparam int CW            = $clog2(STABLE_CYCLES + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg,
    input  logic [DIGITS-1:0]     an,
    output logic [4*DIGITS-1:0]   value,
    output logic [DIGITS-1:0]     digit_valid,
    output logic                  frame_done,
    output logic                  code_err,
    output logic [EW-1:0]         err_digit
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_HELD   = 2'd2;

    // Returns {legal, nibble}; legal is 0 for blank and for any non-hex pattern.
    function automatic logic [4:0] decode_glyph(input logic [6:0] pat);
        case (pat)
            7'h7E:   return {1'b1, 4'h0};
            7'h30:   return {1'b1, 4'h1};
            7'h6D:   return {1'b1, 4'h2};
            7'h79:   return {1'b1, 4'h3};
            7'h33:   return {1'b1, 4'h4};
            7'h5B:   return {1'b1, 4'h5};
            7'h5F:   return {1'b1, 4'h6};
            7'h70:   return {1'b1, 4'h7};
            7'h7F:   return {1'b1, 4'h8};
            7'h7B:   return {1'b1, 4'h9};
            7'h77:   return {1'b1, 4'hA};
            7'h1F:   return {1'b1, 4'hB};
            7'h4E:   return {1'b1, 4'hC};
            7'h3D:   return {1'b1, 4'hD};
            7'h4F:   return {1'b1, 4'hE};
            7'h47:   return {1'b1, 4'hF};
            default: return 5'b0_0000;
        endcase
    endfunction

    logic [DIGITS+6:0]   pair_r;
    logic [1:0]          state_r;
    logic [CW-1:0]       cnt_r;
    logic [4*DIGITS-1:0] value_r;
    logic [DIGITS-1:0]   valid_r;
    logic [DIGITS-1:0]   seen_r;
    logic                frame_done_r;
    logic                code_err_r;
    logic [EW-1:0]       err_digit_r;

    logic [DIGITS+6:0]   pair_s;
    logic                onehot_s;
    logic [EW-1:0]       idx_s;
    logic [DIGITS-1:0]   bit_s;
    logic [4:0]          glyph_s;
    logic                capture_s;
    logic [1:0]          state_n_s;
    logic [CW-1:0]       cnt_n_s;
    logic [4*DIGITS-1:0] value_n_s;
    logic [DIGITS-1:0]   valid_n_s;
    logic [DIGITS-1:0]   seen_n_s;
    logic                frame_done_n_s;
    logic                code_err_n_s;
    logic [EW-1:0]       err_digit_n_s;

    // Classify the current enable vector and locate the selected digit.
    always_comb begin
        pair_s   = {an, seg};
        onehot_s = (an != {DIGITS{1'b0}}) && ((an & (an - DIGITS'(1))) == {DIGITS{1'b0}});
        idx_s    = {EW{1'b0}};
        for (int i = 0; i < DIGITS; i++) begin
            if (an[i]) begin
                idx_s = EW'(i);
            end else begin
                idx_s = idx_s;
            end
        end
        bit_s   = DIGITS'(1) << idx_s;
        glyph_s = decode_glyph(seg);
    end

    // Dwell tracker: any change restarts the run; reaching the threshold fires one capture.
    always_comb begin
        state_n_s = state_r;
        cnt_n_s   = cnt_r;
        capture_s = 1'b0;
        if ((pair_s != pair_r) || (state_r == ST_IDLE)) begin
            if (onehot_s) begin
                state_n_s = ST_SETTLE;
                cnt_n_s   = CW'(1);
            end else begin
                state_n_s = ST_IDLE;
                cnt_n_s   = {CW{1'b0}};
            end
        end else begin
            case (state_r)
                ST_SETTLE: begin
                    if (cnt_r < CW'(STABLE_CYCLES)) begin
                        cnt_n_s = cnt_r + CW'(1);
                    end else begin
                        cnt_n_s = cnt_r;
                    end
                    if (cnt_n_s == CW'(STABLE_CYCLES)) begin
                        state_n_s = ST_HELD;
                        capture_s = 1'b1;
                    end else begin
                        state_n_s = ST_SETTLE;
                    end
                end
                ST_HELD: begin
                    state_n_s = ST_HELD;
                end
                default: begin
                    state_n_s = ST_IDLE;
                    cnt_n_s   = {CW{1'b0}};
                end
            endcase
        end
    end

    // Capture action: update the slot, validity, frame tracking and error reporting.
    always_comb begin
        value_n_s      = value_r;
        valid_n_s      = valid_r;
        seen_n_s       = seen_r;
        frame_done_n_s = 1'b0;
        code_err_n_s   = 1'b0;
        err_digit_n_s  = err_digit_r;
        if (capture_s) begin
            if (glyph_s[4]) begin
                value_n_s[int'(idx_s)*4 +: 4] = glyph_s[3:0];
                valid_n_s = valid_r | bit_s;
                if ((seen_r | bit_s) == {DIGITS{1'b1}}) begin
                    frame_done_n_s = 1'b1;
                    seen_n_s       = {DIGITS{1'b0}};
                end else begin
                    seen_n_s = seen_r | bit_s;
                end
            end else if (seg == 7'h00) begin
                valid_n_s = valid_r & ~bit_s;
            end else begin
                valid_n_s     = valid_r & ~bit_s;
                code_err_n_s  = 1'b1;
                err_digit_n_s = idx_s;
            end
        end else begin
            value_n_s = value_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pair_r       <= {(DIGITS+7){1'b0}};
            state_r      <= ST_IDLE;
            cnt_r        <= {CW{1'b0}};
            value_r      <= {(4*DIGITS){1'b0}};
            valid_r      <= {DIGITS{1'b0}};
            seen_r       <= {DIGITS{1'b0}};
            frame_done_r <= 1'b0;
            code_err_r   <= 1'b0;
            err_digit_r  <= {EW{1'b0}};
        end else begin
            pair_r       <= pair_s;
            state_r      <= state_n_s;
            cnt_r        <= cnt_n_s;
            value_r      <= value_n_s;
            valid_r      <= valid_n_s;
            seen_r       <= seen_n_s;
            frame_done_r <= frame_done_n_s;
            code_err_r   <= code_err_n_s;
            err_digit_r  <= err_digit_n_s;
        end
    end

    assign value       = value_r;
    assign digit_valid = valid_r;
    assign frame_done  = frame_done_r;
    assign code_err    = code_err_r;
    assign err_digit   = err_digit_r;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder (DIGITS=4, STABLE_CYCLES=4) with hand-computed expectations.
module tb_seg7_scan_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  seg = 7'h00;
    logic [3:0]  an = 4'b0000;
    logic [15:0] value;
    logic [3:0]  digit_valid;
    logic        frame_done;
    logic        code_err;
    logic [1:0]  err_digit;

    int checks = 0;
    int errors = 0;
    int fd_cnt = 0;
    int ce_cnt = 0;

    seg7_scan_decoder #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .seg(seg), .an(an),
        .value(value), .digit_valid(digit_valid), .frame_done(frame_done),
        .code_err(code_err), .err_digit(err_digit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive a pair, take one edge, sample 1 time unit later and tally pulses.
    task automatic tick(input logic [3:0] a, input logic [6:0] s);
        an  = a;
        seg = s;
        @(posedge clk);
        #1;
        fd_cnt += int'(frame_done);
        ce_cnt += int'(code_err);
    endtask

    task automatic dwell(input logic [3:0] a, input logic [6:0] s, input int n);
        for (int k = 0; k < n; k++) tick(a, s);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_value"}, 32'(value), 32'h0);
        chk({tag, "_valid"}, 32'(digit_valid), 32'h0);
        chk({tag, "_fd"}, 32'(frame_done), 32'h0);
        chk({tag, "_ce"}, 32'(code_err), 32'h0);
        chk({tag, "_ed"}, 32'(err_digit), 32'h0);
    endtask

    initial begin
        // Reset and idle
        #12;
        rst_n = 1'b1;
        dwell(4'b0000, 7'h00, 3);
        chk_all_zero("idle");

        // Basic decode
        dwell(4'b0001, 7'h6D, 3);
        chk("basic_pre", 32'(digit_valid), 32'h0);
        tick(4'b0001, 7'h6D);
        chk("basic_val", 32'(value), 32'h0002);
        chk("basic_dv", 32'(digit_valid), 32'h1);
        dwell(4'b0001, 7'h6D, 10);
        chk("basic_hold_val", 32'(value), 32'h0002);
        chk("basic_hold_dv", 32'(digit_valid), 32'h1);
        chk("basic_fd_cnt", 32'(fd_cnt), 32'd0);
        chk("basic_ce_cnt", 32'(ce_cnt), 32'd0);

        // Glitch rejection
        dwell(4'b0010, 7'h79, 3);
        chk("glitch_no3", 32'(value), 32'h0002);
        dwell(4'b0010, 7'h33, 3);
        chk("glitch_pre4", 32'(value), 32'h0002);
        tick(4'b0010, 7'h33);
        chk("glitch_val", 32'(value), 32'h0042);
        chk("glitch_dv", 32'(digit_valid), 32'h3);

        // Full scan
        dwell(4'b0001, 7'h7E, 4);
        dwell(4'b0010, 7'h30, 4);
        dwell(4'b0100, 7'h4E, 4);
        dwell(4'b1000, 7'h47, 3);
        chk("scan_fd_early", 32'(frame_done), 32'h0);
        tick(4'b1000, 7'h47);
        chk("scan_fd", 32'(frame_done), 32'h1);
        chk("scan_val", 32'(value), 32'hFC10);
        chk("scan_dv", 32'(digit_valid), 32'hF);
        tick(4'b1000, 7'h47);
        chk("scan_fd_one", 32'(frame_done), 32'h0);
        dwell(4'b0001, 7'h7E, 4);
        dwell(4'b0010, 7'h30, 4);
        dwell(4'b0100, 7'h4E, 4);
        dwell(4'b1000, 7'h47, 6);
        chk("scan2_fd_cnt", 32'(fd_cnt), 32'd2);
        chk("scan2_val", 32'(value), 32'hFC10);

        // Error and blank
        dwell(4'b0100, 7'h01, 4);
        chk("err_ce", 32'(code_err), 32'h1);
        chk("err_ed", 32'(err_digit), 32'h2);
        chk("err_dv", 32'(digit_valid), 32'hB);
        chk("err_val", 32'(value), 32'hFC10);
        tick(4'b0100, 7'h01);
        chk("err_ce_one", 32'(code_err), 32'h0);
        dwell(4'b0100, 7'h00, 4);
        chk("blank_ce_cnt", 32'(ce_cnt), 32'd1);
        chk("blank_dv", 32'(digit_valid), 32'hB);
        chk("blank_ed", 32'(err_digit), 32'h2);

        // Illegal enables
        dwell(4'b0011, 7'h7F, 20);
        chk("multi_val", 32'(value), 32'hFC10);
        chk("multi_dv", 32'(digit_valid), 32'hB);
        chk("multi_fd_cnt", 32'(fd_cnt), 32'd2);
        chk("multi_ce_cnt", 32'(ce_cnt), 32'd1);
        dwell(4'b1000, 7'h7F, 3);
        chk("restart_pre", 32'(value), 32'hFC10);
        tick(4'b1000, 7'h7F);
        chk("restart_val", 32'(value), 32'h8C10);
        chk("restart_fd", 32'(frame_done), 32'h0);

        // Asynchronous reset mid-dwell
        dwell(4'b0001, 7'h30, 2);
        #3;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        an  = 4'b0000;
        seg = 7'h00;
        @(negedge clk);
        rst_n = 1'b1;
        dwell(4'b0000, 7'h00, 5);
        chk_all_zero("post_rst_idle");

        // Dwell in progress at reset release restarts from the first edge
        an  = 4'b0001;
        seg = 7'h30;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        dwell(4'b0001, 7'h30, 3);
        chk("rst_dwell_pre", 32'(digit_valid), 32'h0);
        tick(4'b0001, 7'h30);
        chk("rst_dwell_dv", 32'(digit_valid), 32'h1);
        chk("rst_dwell_val", 32'(value), 32'h0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
